// File: rtl/timer_pkg.sv
// Shared definitions for the timer reload/control stage: FSM states and
// control-register bit positions within DIN.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam int CTRL_EN        = 0;
    localparam int CTRL_PER       = 1;
    localparam int CTRL_PRESC_LSB = 2;

endpackage

// File: rtl/timer_prescale.sv
// CK prescaler: counts CK strobes while stepping and flags a tick when the
// count matches the programmed divide value.
module timer_prescale #(
    parameter int PRESC_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               step,
    input  logic [PRESC_W-1:0] presc,
    output logic               tick
);

    logic [PRESC_W-1:0] presc_cnt;

    assign tick = (presc_cnt == presc);

    // A restart clear wins over a coincident step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_cnt <= '0;
        end else if (clear) begin
            presc_cnt <= '0;
        end else if (step) begin
            presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/timer_reload_ctl.sv
// Reload/control stage for one CTR8 up-counter: CPU registers, prescaler,
// IDLE/ARM/RUN sequencing of LDL/ENAB, terminal-count detection and interrupt.
module timer_reload_ctl
    import timer_pkg::*;
#(
    parameter int PRESC_W = 4,
    parameter int CTR_W   = 8
) (
    input  logic             MasterClock,
    input  logic             RESET,
    input  logic             CK,
    input  logic             WR_RELOAD,
    input  logic             WR_CTRL,
    input  logic [CTR_W-1:0] DIN,
    input  logic             INT_ACK,
    input  logic [CTR_W-1:0] CTR_Q,
    output logic [CTR_W-1:0] CTR_D,
    output logic             CTR_LDL,
    output logic             CTR_ENAB,
    output logic             INT,
    output logic             EXPIRE,
    output logic             RUNNING,
    output state_t           fsm_state
);

    state_t             state, state_nx;
    logic [CTR_W-1:0]   reload;
    logic               periodic;
    logic [PRESC_W-1:0] presc;
    logic               int_q, expire_q;
    logic               tick, term, fire, arm_req;
    logic               unused_din;

    assign arm_req    = WR_CTRL & DIN[CTRL_EN];
    // CTR_Q is the registered output of CTR8, so term adds no input-to-output path.
    assign term       = (state == RUN) & tick & (CTR_Q == {CTR_W{1'b1}});
    assign fire       = CK & term;
    assign unused_din = ^DIN;

    timer_prescale #(.PRESC_W(PRESC_W)) u_prescale (
        .clk   (MasterClock),
        .rst   (RESET),
        .clear (arm_req),
        .step  (CK & (state == RUN)),
        .presc (presc),
        .tick  (tick)
    );

    always_ff @(posedge MasterClock or posedge RESET) begin
        if (RESET) begin
            reload   <= '0;
            periodic <= 1'b0;
            presc    <= '0;
            int_q    <= 1'b0;
            expire_q <= 1'b0;
        end else begin
            if (WR_RELOAD) reload <= DIN;
            if (WR_CTRL) begin
                periodic <= DIN[CTRL_PER];
                presc    <= DIN[CTRL_PRESC_LSB +: PRESC_W];
            end
            expire_q <= fire;
            // INT is a level held until INT_ACK; a same-cycle expiry beats the ack.
            if (fire)         int_q <= 1'b1;
            else if (INT_ACK) int_q <= 1'b0;
        end
    end

    always_ff @(posedge MasterClock or posedge RESET) begin
        if (RESET) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        CTR_LDL  = 1'b1;
        CTR_ENAB = 1'b0;
        RUNNING  = 1'b0;
        case (state)
            IDLE: ;
            ARM: begin
                CTR_LDL = 1'b0;
                RUNNING = 1'b1;
                if (CK) state_nx = RUN;
            end
            RUN: begin
                CTR_ENAB = tick;
                CTR_LDL  = ~term;
                RUNNING  = 1'b1;
                if (fire && !periodic) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        // A control write overrides the terminal-count transition.
        if (WR_CTRL) state_nx = DIN[CTRL_EN] ? ARM : IDLE;
    end

    assign CTR_D     = reload;
    assign INT       = int_q;
    assign EXPIRE    = expire_q;
    assign fsm_state = state;

endmodule
